// File: rtl/map_pkg.sv
// Shared types and defaults for the world-map access path: cell codes, requester ids,
// in-flight read tags, and the built-in grid image served by the map BRAM.
package map_pkg;

    localparam int MAP_N            = 24;
    localparam int MAP_DATA_WIDTH   = 4;
    localparam int MAP_READ_LATENCY = 2;
    localparam int MAP_STARVE_LIMIT = 8;

    typedef logic [MAP_DATA_WIDTH-1:0] cell_t;

    // Out-of-range coordinates read back as a wall so rays always terminate.
    localparam cell_t MAP_OOB_CODE = 4'd1;

    typedef enum logic {
        REQ_CTRL = 1'b0,
        REQ_RAY  = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t who;
        logic    oob;
    } tag_t;

    // Grid image, addressed as x + y*MAP_N: a corner marker at (0,0), a door at (3,2),
    // a pillar at (5,5) and a solid wall along the far row and column.
    function automatic cell_t map_cell(input int unsigned addr);
        int unsigned cx;
        int unsigned cy;
        cx = addr % MAP_N;
        cy = addr / MAP_N;
        if (cx == 3 && cy == 2) return 4'd2;
        if (cx == 0 && cy == 0) return 4'd1;
        if (cx == 5 && cy == 5) return 4'd3;
        if (cx == MAP_N - 1 || cy == MAP_N - 1) return 4'd1;
        return 4'd0;
    endfunction

endpackage

// File: rtl/map_access_arbiter_if.sv
// Request/response bundle between the two map requesters and the map access arbiter.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready. ready is
// combinational and only rises while the matching valid is high; the requester holds
// valid, x and y stable until accepted. rsp_valid is a one-cycle strobe; rsp_data keeps
// its last value between strobes.
interface map_access_arbiter_if #(
    parameter int DATA_WIDTH = map_pkg::MAP_DATA_WIDTH
);
    logic                  ctrl_req_valid;
    logic [7:0]            ctrl_req_x;
    logic [7:0]            ctrl_req_y;
    logic                  ctrl_req_ready;
    logic                  ctrl_rsp_valid;
    logic [DATA_WIDTH-1:0] ctrl_rsp_data;

    logic                  ray_req_valid;
    logic [7:0]            ray_req_x;
    logic [7:0]            ray_req_y;
    logic                  ray_req_ready;
    logic                  ray_rsp_valid;
    logic [DATA_WIDTH-1:0] ray_rsp_data;

    modport master (
        output ctrl_req_valid, ctrl_req_x, ctrl_req_y,
        input  ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_data,
        output ray_req_valid, ray_req_x, ray_req_y,
        input  ray_req_ready, ray_rsp_valid, ray_rsp_data
    );

    modport slave (
        input  ctrl_req_valid, ctrl_req_x, ctrl_req_y,
        output ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_data,
        input  ray_req_valid, ray_req_x, ray_req_y,
        output ray_req_ready, ray_rsp_valid, ray_rsp_data
    );

endinterface

// File: rtl/map_access_arbiter_ram.sv
// Single-port read-first map BRAM with the output register enabled (two-cycle read).
// Contents come from the grid image in map_pkg; the port is read-only in this design.
module xilinx_single_port_ram_read_first
    import map_pkg::*;
#(
    parameter  int RAM_WIDTH = MAP_DATA_WIDTH,
    parameter  int RAM_DEPTH = MAP_N * MAP_N,
    localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    input  logic                 ena,
    input  logic                 rsta,
    input  logic                 regcea,
    output logic [RAM_WIDTH-1:0] douta
);

    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            ram_data <= RAM_WIDTH'(map_cell(32'(addra)));
        end
    end

    // rsta only clears the output register, matching the primitive's behaviour.
    always_ff @(posedge clka) begin
        if (rsta) begin
            douta <= '0;
        end else if (regcea) begin
            douta <= ram_data;
        end
    end

endmodule

// File: rtl/map_access_arbiter.sv
// Shares the single-port map BRAM between the player controller and the raycaster,
// tagging each read so its response returns to the issuer, in order, at fixed latency.
module map_access_arbiter
    import map_pkg::*;
#(
    parameter int N            = MAP_N,
    parameter int DATA_WIDTH   = MAP_DATA_WIDTH,
    parameter int READ_LATENCY = MAP_READ_LATENCY,
    parameter int STARVE_LIMIT = MAP_STARVE_LIMIT,
    parameter logic [DATA_WIDTH-1:0] OOB_CODE = DATA_WIDTH'(MAP_OOB_CODE)
) (
    input  logic pixel_clk_in,
    input  logic rst_in,
    map_access_arbiter_if.slave bus
);

    localparam int ADDR_W = $clog2(N * N);
    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

    logic                  force_ctrl;
    logic                  ray_grant;
    logic                  ctrl_grant;
    logic                  grant_any;
    logic [7:0]            sel_x;
    logic [7:0]            sel_y;
    logic                  req_oob;
    logic                  bram_ena;
    logic [ADDR_W-1:0]     bram_addr;
    logic [DATA_WIDTH-1:0] bram_dout;
    logic [SC_W-1:0]       starve_cnt;
    tag_t                  new_tag;
    tag_t                  tag_pipe [READ_LATENCY];
    tag_t                  head;
    logic [DATA_WIDTH-1:0] rsp_cell;

    // Ray has priority except when ctrl has watched STARVE_LIMIT ray grants go by.
    always_comb begin
        force_ctrl = (starve_cnt >= SC_W'(STARVE_LIMIT));
        ray_grant  = !rst_in && bus.ray_req_valid && !(force_ctrl && bus.ctrl_req_valid);
        ctrl_grant = !rst_in && bus.ctrl_req_valid && !ray_grant;
        grant_any  = ray_grant || ctrl_grant;
    end

    assign bus.ray_req_ready  = ray_grant;
    assign bus.ctrl_req_ready = ctrl_grant;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        if (ray_grant) begin
            sel_x = bus.ray_req_x;
            sel_y = bus.ray_req_y;
        end else if (ctrl_grant) begin
            sel_x = bus.ctrl_req_x;
            sel_y = bus.ctrl_req_y;
        end
        req_oob   = (sel_x >= 8'(N)) || (sel_y >= 8'(N));
        bram_addr = ADDR_W'(sel_x) + ADDR_W'(sel_y) * ADDR_W'(N);
        bram_ena  = grant_any && !req_oob;
        new_tag   = '{valid: grant_any, who: (ray_grant ? REQ_RAY : REQ_CTRL), oob: req_oob};
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            starve_cnt <= '0;
        end else if (!bus.ctrl_req_valid || ctrl_grant) begin
            starve_cnt <= '0;
        end else if (ray_grant && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH (DATA_WIDTH),
        .RAM_DEPTH (N * N)
    ) u_map_ram (
        .clka   (pixel_clk_in),
        .addra  (bram_addr),
        .ena    (bram_ena),
        .rsta   (rst_in),
        .regcea (1'b1),
        .douta  (bram_dout)
    );

    // The last tag stage lines up with douta, since both have seen READ_LATENCY edges.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        head     = tag_pipe[READ_LATENCY-1];
        rsp_cell = head.oob ? OOB_CODE : bram_dout;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            bus.ctrl_rsp_valid <= 1'b0;
            bus.ray_rsp_valid  <= 1'b0;
            bus.ctrl_rsp_data  <= '0;
            bus.ray_rsp_data   <= '0;
        end else begin
            bus.ctrl_rsp_valid <= head.valid && (head.who == REQ_CTRL);
            bus.ray_rsp_valid  <= head.valid && (head.who == REQ_RAY);
            if (head.valid && head.who == REQ_CTRL) begin
                bus.ctrl_rsp_data <= rsp_cell;
            end
            if (head.valid && head.who == REQ_RAY) begin
                bus.ray_rsp_data <= rsp_cell;
            end
        end
    end

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter: grants, latency, out-of-range, starvation, reset.
module tb_map_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  map_access_arbiter_if bus ();

  map_access_arbiter dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] exp_q[$];

  task automatic drive_idle();
    bus.ctrl_req_valid = 1'b0;
    bus.ctrl_req_x     = 8'd0;
    bus.ctrl_req_y     = 8'd0;
    bus.ray_req_valid  = 1'b0;
    bus.ray_req_x      = 8'd0;
    bus.ray_req_y      = 8'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ray(input logic [7:0] x, input logic [7:0] y);
    bus.ray_req_valid = 1'b1;
    bus.ray_req_x     = x;
    bus.ray_req_y     = y;
  endtask

  task automatic drive_ctrl(input logic [7:0] x, input logic [7:0] y);
    bus.ctrl_req_valid = 1'b1;
    bus.ctrl_req_x     = x;
    bus.ctrl_req_y     = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    drive_ray(8'd3, 8'd2);
    drive_ctrl(8'd4, 8'd4);
    repeat (3) step();
    @(negedge clk);
    n_vec++; if (bus.ray_req_ready !== 1'b0) begin n_miss++; $display("FAIL reset_ray_ready got %b want 0", bus.ray_req_ready); end
    n_vec++; if (bus.ctrl_req_ready !== 1'b0) begin n_miss++; $display("FAIL reset_ctrl_ready got %b want 0", bus.ctrl_req_ready); end
    n_vec++; if (bus.ray_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_ray_rsp_valid got %b want 0", bus.ray_rsp_valid); end
    n_vec++; if (bus.ctrl_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_ctrl_rsp_valid got %b want 0", bus.ctrl_rsp_valid); end
    n_vec++; if (bus.ray_rsp_data !== 4'd0) begin n_miss++; $display("FAIL reset_ray_rsp_data got %0d want 0", bus.ray_rsp_data); end
    n_vec++; if (bus.ctrl_rsp_data !== 4'd0) begin n_miss++; $display("FAIL reset_ctrl_rsp_data got %0d want 0", bus.ctrl_rsp_data); end
    n_vec++; if (dut.starve_cnt !== 4'd0) begin n_miss++; $display("FAIL reset_starve_cnt got %0d want 0", dut.starve_cnt); end
    step();
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_ray_single();
    for (int c = 0; c < 6; c++) begin
      step();
      drive_idle();
      if (c == 0) drive_ray(8'd3, 8'd2);
      @(negedge clk);
      if (c == 0) begin
        n_vec++; if (bus.ray_req_ready !== 1'b1) begin n_miss++; $display("FAIL ray_single_ready got %b want 1", bus.ray_req_ready); end
        n_vec++; if (bus.ctrl_req_ready !== 1'b0) begin n_miss++; $display("FAIL ray_single_ctrl_ready got %b want 0", bus.ctrl_req_ready); end
      end
      n_vec++; if (bus.ray_rsp_valid !== (c == 3)) begin n_miss++; $display("FAIL ray_single_rsp_valid c=%0d got %b want %b", c, bus.ray_rsp_valid, (c == 3)); end
      n_vec++; if (bus.ctrl_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL ray_single_ctrl_rsp_valid c=%0d got %b want 0", c, bus.ctrl_rsp_valid); end
      if (c == 3) begin
        n_vec++; if (bus.ray_rsp_data !== 4'd2) begin n_miss++; $display("FAIL ray_single_data got %0d want 2", bus.ray_rsp_data); end
      end
    end
  endtask

  task automatic test_ctrl_oob();
    for (int c = 0; c < 6; c++) begin
      step();
      drive_idle();
      if (c == 0) drive_ctrl(8'd24, 8'd5);
      @(negedge clk);
      if (c == 0) begin
        n_vec++; if (bus.ctrl_req_ready !== 1'b1) begin n_miss++; $display("FAIL oob_ready got %b want 1", bus.ctrl_req_ready); end
      end
      n_vec++; if (dut.bram_ena !== 1'b0) begin n_miss++; $display("FAIL oob_bram_ena c=%0d got %b want 0", c, dut.bram_ena); end
      n_vec++; if (bus.ctrl_rsp_valid !== (c == 3)) begin n_miss++; $display("FAIL oob_rsp_valid c=%0d got %b want %b", c, bus.ctrl_rsp_valid, (c == 3)); end
      n_vec++; if (bus.ray_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL oob_ray_rsp_valid c=%0d got %b want 0", c, bus.ray_rsp_valid); end
      if (c == 3) begin
        n_vec++; if (bus.ctrl_rsp_data !== 4'd1) begin n_miss++; $display("FAIL oob_data got %0d want 1", bus.ctrl_rsp_data); end
      end
    end
  endtask

  task automatic test_ctrl_center();
    for (int c = 0; c < 6; c++) begin
      step();
      drive_idle();
      if (c == 0) drive_ctrl(8'd12, 8'd12);
      @(negedge clk);
      if (c == 0) begin
        n_vec++; if (bus.ctrl_req_ready !== 1'b1) begin n_miss++; $display("FAIL center_ready got %b want 1", bus.ctrl_req_ready); end
      end
      n_vec++; if (bus.ctrl_rsp_valid !== (c == 3)) begin n_miss++; $display("FAIL center_rsp_valid c=%0d got %b want %b", c, bus.ctrl_rsp_valid, (c == 3)); end
      n_vec++; if (bus.ray_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL center_ray_rsp_valid c=%0d got %b want 0", c, bus.ray_rsp_valid); end
      if (c == 3) begin
        n_vec++; if (bus.ctrl_rsp_data !== 4'd0) begin n_miss++; $display("FAIL center_data got %0d want 0", bus.ctrl_rsp_data); end
      end
      if (c == 5) begin
        n_vec++; if (bus.ray_rsp_data !== 4'd2) begin n_miss++; $display("FAIL center_ray_data_hold got %0d want 2", bus.ray_rsp_data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      drive_idle();
      if (c < 3) drive_ray(8'(c), 8'd0);
      @(negedge clk);
      if (c < 3) begin
        n_vec++; if (bus.ray_req_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready c=%0d got %b want 1", c, bus.ray_req_ready); end
      end
      if (c >= 3 && c < 6) begin
        n_vec++; if (bus.ray_rsp_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_rsp_valid c=%0d got %b want 1", c, bus.ray_rsp_valid); end
        n_vec++; if (bus.ray_rsp_data !== exp_q[0]) begin n_miss++; $display("FAIL b2b_data c=%0d got %0d want %0d", c, bus.ray_rsp_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end else begin
        n_vec++; if (bus.ray_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_rsp_idle c=%0d got %b want 0", c, bus.ray_rsp_valid); end
      end
      n_vec++; if (bus.ctrl_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_ctrl_rsp_valid c=%0d got %b want 0", c, bus.ctrl_rsp_valid); end
    end
  endtask

  task automatic test_starve();
    logic exp_ctrl;
    for (int c = 0; c < 27; c++) begin
      step();
      drive_ray(8'd1, 8'd0);
      drive_ctrl(8'd2, 8'd0);
      @(negedge clk);
      exp_ctrl = ((c % 9) == 8);
      n_vec++; if (bus.ctrl_req_ready !== exp_ctrl) begin n_miss++; $display("FAIL starve_ctrl_ready c=%0d got %b want %b", c, bus.ctrl_req_ready, exp_ctrl); end
      n_vec++; if (bus.ray_req_ready !== !exp_ctrl) begin n_miss++; $display("FAIL starve_ray_ready c=%0d got %b want %b", c, bus.ray_req_ready, !exp_ctrl); end
      n_vec++; if (dut.starve_cnt !== 4'(c % 9)) begin n_miss++; $display("FAIL starve_cnt c=%0d got %0d want %0d", c, dut.starve_cnt, c % 9); end
    end
    step();
    drive_idle();
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      step();
      drive_idle();
      rst = 1'b0;
      if (c == 0) drive_ctrl(8'd4, 8'd4);
      if (c == 1) rst = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        n_vec++; if (bus.ctrl_req_ready !== 1'b1) begin n_miss++; $display("FAIL rstmid_ready got %b want 1", bus.ctrl_req_ready); end
      end
      if (c == 2) begin
        n_vec++; if (dut.starve_cnt !== 4'd0) begin n_miss++; $display("FAIL rstmid_starve_cnt got %0d want 0", dut.starve_cnt); end
      end
      n_vec++; if (bus.ctrl_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rstmid_no_rsp c=%0d got %b want 0", c, bus.ctrl_rsp_valid); end
    end
    for (int c = 0; c < 6; c++) begin
      step();
      drive_idle();
      if (c == 0) drive_ctrl(8'd3, 8'd2);
      @(negedge clk);
      n_vec++; if (bus.ctrl_rsp_valid !== (c == 3)) begin n_miss++; $display("FAIL rstmid_after_valid c=%0d got %b want %b", c, bus.ctrl_rsp_valid, (c == 3)); end
      if (c == 3) begin
        n_vec++; if (bus.ctrl_rsp_data !== 4'd2) begin n_miss++; $display("FAIL rstmid_after_data got %0d want 2", bus.ctrl_rsp_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ray_single();
    test_ctrl_oob();
    test_ctrl_center();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
